// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// the R-type funct mapping used by the decoder.
package MDUops;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } mdu_state_t;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  function automatic logic [1:0] funct_to_op(input logic [5:0] funct);
    logic [1:0] res;
    case (funct)
      FUNCT_MULTU: res = MDU_MULTU;
      FUNCT_DIV:   res = MDU_DIV;
      FUNCT_DIVU:  res = MDU_DIVU;
      default:     res = MDU_MULT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational two's-complement conditional negate: yields |val| when fed
// the sign bit, or applies a recorded result sign during fix-up.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; 34 cycles start-to-done.
// Shift-add multiply and restoring divide share one 64-bit accumulator.
module muldiv_unit
  import MDUops::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  mdu_state_t        state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   a_orig;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              dz;

  // MULT and DIV are the signed ops; both have op[0] clear.
  logic            signed_in;
  logic [XLEN-1:0] mag_a, mag_b;

  assign signed_in = ~op[0];

  mdu_sign_fix #(.W(XLEN)) u_mag_a (.val(a), .neg(signed_in & a[XLEN-1]), .res(mag_a));
  mdu_sign_fix #(.W(XLEN)) u_mag_b (.val(b), .neg(signed_in & b[XLEN-1]), .res(mag_b));

  // Multiply step: acc = {partial_hi, remaining multiplier bits}.
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_next;

  assign add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
  assign mul_next = {add_sum, acc[XLEN-1:1]};

  // Divide step: acc = {partial remainder, dividend bits shifting into quotient}.
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] div_next;

  assign shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff     = shifted - {1'b0, opnd};
  assign div_next = diff[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],    acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  mdu_sign_fix #(.W(2*XLEN)) u_prod_fix (.val(acc), .neg(neg_q), .res(prod_fix));
  mdu_sign_fix #(.W(XLEN)) u_quo_fix (.val(acc[XLEN-1:0]), .neg(neg_q), .res(quo_fix));
  mdu_sign_fix #(.W(XLEN)) u_rem_fix (.val(acc[2*XLEN-1:XLEN]), .neg(neg_r), .res(rem_fix));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST_ITER) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIN);
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            is_div <= op[1];
            a_orig <= a;
            dz     <= op[1] && (b == '0);
            neg_q  <= signed_in & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r  <= signed_in & a[XLEN-1];
            opnd   <= op[1] ? mag_b : mag_a;
            acc    <= {{XLEN{1'b0}}, (op[1] ? mag_a : mag_b)};
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= is_div ? div_next : mul_next;
        end
        FIN: begin
          // Divide by zero reports the raw dividend and bypasses sign fix-up.
          if (dz) begin
            hi <= a_orig;
            lo <= {XLEN{1'b1}};
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*XLEN-1:XLEN];
            lo <= prod_fix[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, MTHI/MTLO,
// busy-time filtering and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one op, then follows it cycle by cycle until done (bounded).
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int nb;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " busy_cycles"}, 64'(nb), 64'd33);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(ehi));
    chk({tag, " lo"}, 64'(lo), 64'(elo));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_pos_negdiv", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_plain", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI alone, then MTHI+MTLO together.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo_untouched", 64'(lo), 64'hFFFF_FFFF);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo hi", 64'(hi), 64'hA5A5_A5A5);
    chk("mthilo lo", 64'(lo), 64'hA5A5_A5A5);

    // start beats a same-cycle MTLO; MTLO and start during CALC are ignored.
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5; lo_we = 1'b1; wdata = 32'h0000_0BAD;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    chk("start_wins lo", 64'(lo), 64'hA5A5_A5A5);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    chk("calc mtlo_ignored", 64'(lo), 64'hA5A5_A5A5);
    chk("calc busy", 64'(busy), 64'd1);
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("calc single_done", 64'(ndone), 64'd1);
    chk("calc hi", 64'(hi), 64'd0);
    chk("calc lo", 64'(lo), 64'd15);

    // Reset in the middle of a DIVU.
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("midrst no_done", 64'(ndone), 64'd0);

    run_op("after_rst_multu", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
